// File: rtl/led_effect_sequencer.sv
// ---------------------------------------------------------------------------
// led_effect_sequencer
//
// Top-level LED effect controller. Selects the active effect (off, rainbow,
// inverted rainbow, white breathe), steps the fade speed, holds the rainbow
// datapath in reset whenever it is unused or a mode switch is in progress,
// and registers the final 7-bit R/G/B duties for the PWM stage.
//
// Ports:
//   I_CLK_100MHZ          system clock (only clock)
//   I_RST                 asynchronous active-high reset
//   I_CE_10KHZ            one-cycle 10 kHz clock enable (breathe timebase)
//   I_MODE_NEXT           one-cycle pulse, advance effect mode
//   I_SPEED_NEXT          one-cycle pulse, advance speed step
//   I_DUTY_R/G/B          duties from the rainbow datapath
//   O_TIMER               speed timer value for rainbow and breathe
//   O_BRIGHTNESS          peak duty (constant BRIGHTNESS)
//   O_INVERTED            rainbow direction select
//   O_RAINBOW_RST         synchronous reset to the rainbow datapath
//   O_DUTY_R/G/B          final duties to the PWM
//   O_MODE                current mode (0 OFF, 1 RAINBOW, 2 RAINBOW_INV, 3 BREATHE)
//   O_BUSY                high while a mode switch is in progress
// ---------------------------------------------------------------------------
module led_effect_sequencer #(
  parameter logic [6:0] BRIGHTNESS    = 7'd100,
  parameter logic [9:0] TIMER_S0      = 10'd0,
  parameter logic [9:0] TIMER_S1      = 10'd9,
  parameter logic [9:0] TIMER_S2      = 10'd49,
  parameter logic [9:0] TIMER_S3      = 10'd199,
  parameter logic [3:0] SWITCH_CYCLES = 4'd2
) (
  input  logic       I_CLK_100MHZ,
  input  logic       I_RST,
  input  logic       I_CE_10KHZ,
  input  logic       I_MODE_NEXT,
  input  logic       I_SPEED_NEXT,
  input  logic [6:0] I_DUTY_R,
  input  logic [6:0] I_DUTY_G,
  input  logic [6:0] I_DUTY_B,
  output logic [9:0] O_TIMER,
  output logic [6:0] O_BRIGHTNESS,
  output logic       O_INVERTED,
  output logic       O_RAINBOW_RST,
  output logic [6:0] O_DUTY_R,
  output logic [6:0] O_DUTY_G,
  output logic [6:0] O_DUTY_B,
  output logic [1:0] O_MODE,
  output logic       O_BUSY
);

  typedef enum logic {ST_STEADY = 1'b0, ST_SWITCH = 1'b1} state_t;

  localparam logic [1:0] MODE_OFF         = 2'd0;
  localparam logic [1:0] MODE_RAINBOW     = 2'd1;
  localparam logic [1:0] MODE_RAINBOW_INV = 2'd2;
  localparam logic [1:0] MODE_BREATHE     = 2'd3;

  // FSM state
  state_t     r_state;
  logic [1:0] r_mode;
  logic [1:0] r_target;
  logic [3:0] r_sw_cnt;
  logic [1:0] r_speed;

  // Breathe generator state
  logic [6:0] r_level;
  logic       r_dir_down;
  logic [9:0] r_tick_cnt;

  // Registered outputs
  logic [9:0] r_timer;
  logic       r_busy;
  logic       r_rainbow_rst;
  logic       r_inverted;
  logic [6:0] r_duty_r;
  logic [6:0] r_duty_g;
  logic [6:0] r_duty_b;

  // Next-state / next-output values
  state_t     w_state_next;
  logic [1:0] w_mode_next;
  logic [1:0] w_target_next;
  logic [3:0] w_sw_cnt_next;
  logic [1:0] w_speed_next;
  logic [9:0] w_timer_next;
  logic       w_breathe_active;
  logic       w_tick;
  logic [6:0] w_level_next;
  logic       w_dir_down_next;
  logic [9:0] w_tick_cnt_next;
  logic       w_busy_next;
  logic       w_rainbow_rst_next;
  logic       w_inverted_next;
  logic [6:0] w_duty_r_next;
  logic [6:0] w_duty_g_next;
  logic [6:0] w_duty_b_next;

  // -------------------------------------------------------------------------
  // Process 1: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      r_state  <= ST_STEADY;
      r_mode   <= MODE_OFF;
      r_target <= MODE_OFF;
      r_sw_cnt <= 4'd0;
      r_speed  <= 2'd1;
    end else begin
      r_state  <= w_state_next;
      r_mode   <= w_mode_next;
      r_target <= w_target_next;
      r_sw_cnt <= w_sw_cnt_next;
      r_speed  <= w_speed_next;
    end
  end

  // -------------------------------------------------------------------------
  // Process 2: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every combinational output is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_state_next  = r_state;
    w_mode_next   = r_mode;
    w_target_next = r_target;
    w_sw_cnt_next = r_sw_cnt;
    w_speed_next  = I_SPEED_NEXT ? r_speed + 2'd1 : r_speed;

    unique case (r_state)
      ST_STEADY: begin
        if (I_MODE_NEXT) begin
          w_state_next  = ST_SWITCH;
          w_target_next = r_mode + 2'd1;
          w_sw_cnt_next = SWITCH_CYCLES - 4'd1;
        end
      end
      ST_SWITCH: begin
        // Mode pulses are deliberately ignored here (not queued).
        if (r_sw_cnt == 4'd0) begin
          w_state_next = ST_STEADY;
          w_mode_next  = r_target;
        end else begin
          w_sw_cnt_next = r_sw_cnt - 4'd1;
        end
      end
      default: w_state_next = ST_STEADY;
    endcase
  end

  // Speed index to timer value; speed changes land on O_TIMER next edge.
  always_comb begin
    unique case (w_speed_next)
      2'd0:    w_timer_next = TIMER_S0;
      2'd1:    w_timer_next = TIMER_S1;
      2'd2:    w_timer_next = TIMER_S2;
      default: w_timer_next = TIMER_S3;
    endcase
  end

  // Breathe triangle generator; runs only while steady in BREATHE, otherwise
  // parked at level 0 / up / counter 0 so each entry starts from black.
  // The counter compares against the current O_TIMER; after a speed step to a
  // smaller timer it may run up through 10'h3FF before matching again.
  always_comb begin
    w_breathe_active = (r_state == ST_STEADY) && (r_mode == MODE_BREATHE);
    w_tick           = 1'b0;
    w_level_next     = r_level;
    w_dir_down_next  = r_dir_down;
    w_tick_cnt_next  = r_tick_cnt;

    if (!w_breathe_active) begin
      w_level_next    = 7'd0;
      w_dir_down_next = 1'b0;
      w_tick_cnt_next = 10'd0;
    end else if (I_CE_10KHZ) begin
      if (r_tick_cnt == r_timer) begin
        w_tick_cnt_next = 10'd0;
        w_tick          = 1'b1;
      end else begin
        w_tick_cnt_next = r_tick_cnt + 10'd1;
      end
    end

    if (w_tick) begin
      if (!r_dir_down) begin
        if (r_level == BRIGHTNESS) begin
          w_dir_down_next = 1'b1;
          w_level_next    = r_level - 7'd1;
        end else begin
          w_level_next = r_level + 7'd1;
        end
      end else begin
        if (r_level == 7'd0) begin
          w_dir_down_next = 1'b0;
          w_level_next    = r_level + 7'd1;
        end else begin
          w_level_next = r_level - 7'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Process 3: output logic (decoded from the next state so the registered
  // outputs line up with the state they describe)
  // -------------------------------------------------------------------------
  always_comb begin
    w_busy_next        = (w_state_next == ST_SWITCH);
    w_rainbow_rst_next = 1'b1;
    w_inverted_next    = 1'b0;
    w_duty_r_next      = 7'd0;
    w_duty_g_next      = 7'd0;
    w_duty_b_next      = 7'd0;

    if (w_state_next == ST_STEADY) begin
      unique case (w_mode_next)
        MODE_RAINBOW, MODE_RAINBOW_INV: begin
          w_rainbow_rst_next = 1'b0;
          w_inverted_next    = (w_mode_next == MODE_RAINBOW_INV);
          w_duty_r_next      = I_DUTY_R;
          w_duty_g_next      = I_DUTY_G;
          w_duty_b_next      = I_DUTY_B;
        end
        MODE_BREATHE: begin
          w_duty_r_next = w_level_next;
          w_duty_g_next = w_level_next;
          w_duty_b_next = w_level_next;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      r_level       <= 7'd0;
      r_dir_down    <= 1'b0;
      r_tick_cnt    <= 10'd0;
      r_timer       <= TIMER_S1;
      r_busy        <= 1'b0;
      r_rainbow_rst <= 1'b1;
      r_inverted    <= 1'b0;
      r_duty_r      <= 7'd0;
      r_duty_g      <= 7'd0;
      r_duty_b      <= 7'd0;
    end else begin
      r_level       <= w_level_next;
      r_dir_down    <= w_dir_down_next;
      r_tick_cnt    <= w_tick_cnt_next;
      r_timer       <= w_timer_next;
      r_busy        <= w_busy_next;
      r_rainbow_rst <= w_rainbow_rst_next;
      r_inverted    <= w_inverted_next;
      r_duty_r      <= w_duty_r_next;
      r_duty_g      <= w_duty_g_next;
      r_duty_b      <= w_duty_b_next;
    end
  end

  assign O_TIMER       = r_timer;
  assign O_BRIGHTNESS  = BRIGHTNESS;
  assign O_INVERTED    = r_inverted;
  assign O_RAINBOW_RST = r_rainbow_rst;
  assign O_DUTY_R      = r_duty_r;
  assign O_DUTY_G      = r_duty_g;
  assign O_DUTY_B      = r_duty_b;
  assign O_MODE        = r_mode;
  assign O_BUSY        = r_busy;

endmodule

// File: tb/tb_led_effect_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_effect_sequencer
//
// Self-checking bench for led_effect_sequencer. A behavioural model tracks
// mode, remaining switch cycles, speed index and the number of breathe ticks;
// the breathe level is derived arithmetically from the tick count as a
// triangle wave. Inputs are driven on the falling edge, outputs sampled there.
// ---------------------------------------------------------------------------
module tb_led_effect_sequencer;

  localparam int B  = 100;
  localparam int SW = 2;

  logic       I_CLK_100MHZ = 1'b0;
  logic       I_RST        = 1'b0;
  logic       I_CE_10KHZ   = 1'b0;
  logic       I_MODE_NEXT  = 1'b0;
  logic       I_SPEED_NEXT = 1'b0;
  logic [6:0] I_DUTY_R = 7'd0, I_DUTY_G = 7'd0, I_DUTY_B = 7'd0;
  logic [9:0] O_TIMER;
  logic [6:0] O_BRIGHTNESS;
  logic       O_INVERTED, O_RAINBOW_RST, O_BUSY;
  logic [6:0] O_DUTY_R, O_DUTY_G, O_DUTY_B;
  logic [1:0] O_MODE;

  led_effect_sequencer dut (
    .I_CLK_100MHZ (I_CLK_100MHZ),
    .I_RST        (I_RST),
    .I_CE_10KHZ   (I_CE_10KHZ),
    .I_MODE_NEXT  (I_MODE_NEXT),
    .I_SPEED_NEXT (I_SPEED_NEXT),
    .I_DUTY_R     (I_DUTY_R),
    .I_DUTY_G     (I_DUTY_G),
    .I_DUTY_B     (I_DUTY_B),
    .O_TIMER      (O_TIMER),
    .O_BRIGHTNESS (O_BRIGHTNESS),
    .O_INVERTED   (O_INVERTED),
    .O_RAINBOW_RST(O_RAINBOW_RST),
    .O_DUTY_R     (O_DUTY_R),
    .O_DUTY_G     (O_DUTY_G),
    .O_DUTY_B     (O_DUTY_B),
    .O_MODE       (O_MODE),
    .O_BUSY       (O_BUSY)
  );

  always #5 I_CLK_100MHZ = ~I_CLK_100MHZ;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural reference model ----------------
  int m_mode, m_target, m_busy_left, m_speed, m_cnt, m_ticks;
  int m_dr, m_dg, m_db;
  logic [4:0]  e_ctrl;   // {mode, busy, rainbow_rst, inverted}
  logic [9:0]  e_timer;
  logic [20:0] e_duty;

  function automatic int timer_of(input int s);
    case (s)
      0:       return 0;
      1:       return 9;
      2:       return 49;
      default: return 199;
    endcase
  endfunction

  function automatic int tri_level(input int t);
    int p;
    p = t % (2 * B);
    return (p <= B) ? p : (2 * B - p);
  endfunction

  task automatic model_outputs();
    logic busy;
    int   lvl;
    busy    = (m_busy_left > 0);
    e_ctrl  = {m_mode[1:0], busy,
               busy || m_mode == 0 || m_mode == 3,
               !busy && m_mode == 2};
    e_timer = 10'(timer_of(m_speed));
    if (busy || m_mode == 0)      e_duty = 21'd0;
    else if (m_mode == 3) begin
      lvl    = tri_level(m_ticks);
      e_duty = {lvl[6:0], lvl[6:0], lvl[6:0]};
    end else                      e_duty = {m_dr[6:0], m_dg[6:0], m_db[6:0]};
  endtask

  always @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      m_mode = 0; m_target = 0; m_busy_left = 0; m_speed = 1;
      m_cnt = 0; m_ticks = 0; m_dr = 0; m_dg = 0; m_db = 0;
    end else begin
      if (!(m_busy_left == 0 && m_mode == 3)) begin
        m_cnt = 0; m_ticks = 0;
      end else if (I_CE_10KHZ) begin
        if (m_cnt == timer_of(m_speed)) begin m_cnt = 0; m_ticks++; end
        else m_cnt = (m_cnt + 1) % 1024;
      end
      if (I_SPEED_NEXT) m_speed = (m_speed + 1) % 4;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_mode = m_target;
      end else if (I_MODE_NEXT) begin
        m_busy_left = SW;
        m_target    = (m_mode + 1) % 4;
      end
      m_dr = I_DUTY_R; m_dg = I_DUTY_G; m_db = I_DUTY_B;
    end
    model_outputs();
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic m, input logic s, input logic c);
    I_MODE_NEXT = m; I_SPEED_NEXT = s; I_CE_10KHZ = c;
    @(negedge I_CLK_100MHZ);
    I_MODE_NEXT = 1'b0; I_SPEED_NEXT = 1'b0; I_CE_10KHZ = 1'b0;
  endtask

  task automatic do_reset();
    I_RST = 1'b1;
    @(negedge I_CLK_100MHZ);
    @(negedge I_CLK_100MHZ);
    I_RST = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    I_RST = 1'b1;
    @(negedge I_CLK_100MHZ);
    n_cmp++;
    if ({O_MODE, O_BUSY, O_RAINBOW_RST, O_INVERTED} !== 5'b00010) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00010",
               {O_MODE, O_BUSY, O_RAINBOW_RST, O_INVERTED});
    end
    @(negedge I_CLK_100MHZ);
    I_RST = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      I_DUTY_R = 7'($urandom); I_DUTY_G = 7'($urandom); I_DUTY_B = 7'($urandom);
      cyc(1'b0, 1'b0, 1'($urandom));
    end
    n_cmp++;
    if ({O_MODE, O_BUSY, O_RAINBOW_RST, O_INVERTED, O_TIMER,
         O_DUTY_R, O_DUTY_G, O_DUTY_B} !== {5'b00010, 10'd9, 21'd0}) begin
      n_bad++;
      $display("FAIL idle_state: mode=%0d busy=%b rst=%b inv=%b timer=%0d duty=%0d/%0d/%0d want 0/0/1/0/9/0/0/0",
               O_MODE, O_BUSY, O_RAINBOW_RST, O_INVERTED, O_TIMER,
               O_DUTY_R, O_DUTY_G, O_DUTY_B);
    end
    n_cmp++;
    if (O_BRIGHTNESS !== 7'd100) begin
      n_bad++;
      $display("FAIL brightness: got %0d want 100", O_BRIGHTNESS);
    end
  endtask

  task automatic test_switch();
    logic [2:0] busy_seen;
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    busy_seen[2] = O_BUSY;
    cyc(1'b0, 1'b0, 1'b0);
    busy_seen[1] = O_BUSY;
    cyc(1'b0, 1'b0, 1'b0);
    busy_seen[0] = O_BUSY;
    n_cmp++;
    if (busy_seen !== 3'b110) begin
      n_bad++;
      $display("FAIL busy_width: busy per cycle %b want 110", busy_seen);
    end
    n_cmp++;
    if (O_MODE !== 2'd1 || O_RAINBOW_RST !== 1'b0) begin
      n_bad++;
      $display("FAIL enter_rainbow: mode=%0d rst=%b want 1/0", O_MODE, O_RAINBOW_RST);
    end
    I_DUTY_R = 7'd42;
    cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (O_DUTY_R !== 7'd42) begin
      n_bad++;
      $display("FAIL duty_pass: got %0d want 42", O_DUTY_R);
    end
  endtask

  task automatic test_mode_cycle();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      repeat (9) cyc(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (O_MODE !== 2'(k % 4) || O_INVERTED !== (k % 4 == 2)) begin
        n_bad++;
        $display("FAIL mode_step%0d: mode=%0d inv=%b want %0d/%b",
                 k, O_MODE, O_INVERTED, k % 4, (k % 4 == 2));
      end
    end
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);   // lands inside SWITCH, must be dropped
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (O_MODE !== 2'd1 || O_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_in_switch: mode=%0d busy=%b want 1/0", O_MODE, O_BUSY);
    end
  endtask

  task automatic test_breathe();
    int max_seen;
    do_reset();
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (O_TIMER !== 10'd0) begin
      n_bad++;
      $display("FAIL speed0_timer: got %0d want 0", O_TIMER);
    end
    repeat (3) begin
      cyc(1'b1, 1'b0, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
    end
    max_seen = 0;
    for (int i = 1; i <= 200; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      if (int'(O_DUTY_R) > max_seen) max_seen = int'(O_DUTY_R);
      if (i == 100) begin
        n_cmp++;
        if ({O_DUTY_R, O_DUTY_G, O_DUTY_B} !== {7'd100, 7'd100, 7'd100}) begin
          n_bad++;
          $display("FAIL breathe_peak: got %0d/%0d/%0d want 100", O_DUTY_R, O_DUTY_G, O_DUTY_B);
        end
      end
    end
    n_cmp++;
    if ({O_DUTY_R, O_DUTY_G, O_DUTY_B} !== 21'd0) begin
      n_bad++;
      $display("FAIL breathe_floor: got %0d/%0d/%0d want 0", O_DUTY_R, O_DUTY_G, O_DUTY_B);
    end
    n_cmp++;
    if (max_seen > 100) begin
      n_bad++;
      $display("FAIL breathe_max: got %0d want <=100", max_seen);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (O_TIMER !== 10'd49 || O_BUSY !== 1'b1) begin
      n_bad++;
      $display("FAIL simul_edge: timer=%0d busy=%b want 49/1", O_TIMER, O_BUSY);
    end
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (O_MODE !== 2'd2 || O_INVERTED !== 1'b1 || O_RAINBOW_RST !== 1'b0) begin
      n_bad++;
      $display("FAIL simul_mode: mode=%0d inv=%b rst=%b want 2/1/0",
               O_MODE, O_INVERTED, O_RAINBOW_RST);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    #2 I_RST = 1'b1;
    #1;
    n_cmp++;
    if ({O_MODE, O_BUSY, O_RAINBOW_RST, O_TIMER} !== {2'd0, 1'b0, 1'b1, 10'd9}) begin
      n_bad++;
      $display("FAIL async_mid_switch: mode=%0d busy=%b rst=%b timer=%0d want 0/0/1/9",
               O_MODE, O_BUSY, O_RAINBOW_RST, O_TIMER);
    end
    @(negedge I_CLK_100MHZ);
    I_RST = 1'b0;
    repeat (3) begin
      cyc(1'b1, 1'b0, 1'b0);
      repeat (4) cyc(1'b0, 1'b0, 1'b0);
    end
    repeat (100) cyc(1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({O_DUTY_R, O_DUTY_G, O_DUTY_B} !== e_duty || O_DUTY_R === 7'd0) begin
      n_bad++;
      $display("FAIL breathe_before_rst: got %0d want %0d (nonzero)", O_DUTY_R, e_duty[20:14]);
    end
    #2 I_RST = 1'b1;
    #1;
    n_cmp++;
    if ({O_MODE, O_DUTY_R, O_DUTY_G, O_DUTY_B, O_RAINBOW_RST} !== {2'd0, 21'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL async_mid_breathe: mode=%0d duty=%0d/%0d/%0d rst=%b want 0/0/0/0/1",
               O_MODE, O_DUTY_R, O_DUTY_G, O_DUTY_B, O_RAINBOW_RST);
    end
    @(negedge I_CLK_100MHZ);
    I_RST = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (O_MODE !== 2'd1 || O_BUSY !== 1'b0 || O_TIMER !== 10'd9) begin
      n_bad++;
      $display("FAIL after_rst_switch: mode=%0d busy=%b timer=%0d want 1/0/9",
               O_MODE, O_BUSY, O_TIMER);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      I_DUTY_R = 7'($urandom); I_DUTY_G = 7'($urandom); I_DUTY_B = 7'($urandom);
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, 1'($urandom));
      n_cmp++;
      if ({O_MODE, O_BUSY, O_RAINBOW_RST, O_INVERTED} !== e_ctrl) begin
        n_bad++;
        $display("FAIL rnd_ctrl@%0d: got %b want %b", i,
                 {O_MODE, O_BUSY, O_RAINBOW_RST, O_INVERTED}, e_ctrl);
      end
      n_cmp++;
      if (O_TIMER !== e_timer) begin
        n_bad++;
        $display("FAIL rnd_timer@%0d: got %0d want %0d", i, O_TIMER, e_timer);
      end
      n_cmp++;
      if ({O_DUTY_R, O_DUTY_G, O_DUTY_B} !== e_duty) begin
        n_bad++;
        $display("FAIL rnd_duty@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i,
                 O_DUTY_R, O_DUTY_G, O_DUTY_B, e_duty[20:14], e_duty[13:7], e_duty[6:0]);
      end
    end
  endtask

  initial begin
    @(negedge I_CLK_100MHZ);
    test_reset();
    test_switch();
    test_mode_cycle();
    test_breathe();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
